// File: rtl/oam_line_scanner.sv
// oam_line_scanner
// Reads every OAM entry during horizontal blanking and keeps the first SLOTS
// enabled objects that overlap the next scanline in a shadow buffer. At the
// end of each line the shadow buffer moves into the active buffer. During
// active video the active buffer is searched per pixel. The highest-priority
// (lowest slot) object covering x is presented as a registered 32-bit word.
module oam_line_scanner #(
  parameter int OAM_DEPTH = 8,
  parameter int SLOTS     = 4,
  parameter int TILE_W    = 32,
  parameter int TILE_H    = 32,
  parameter int H_VISIBLE = 640,
  parameter int H_TOTAL   = 800,
  parameter int V_TOTAL   = 525
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [9:0]                   x,
  input  logic [9:0]                   y,
  input  logic                         video_on,
  input  logic [31:0]                  oam_rd_data,
  output logic [$clog2(OAM_DEPTH)-1:0] oam_addr,
  output logic [31:0]                  oam_data,
  output logic                         line_overflow,
  output logic                         scan_busy
);

  // phase counts 0..OAM_DEPTH; count holds 0..SLOTS
  localparam int PW = $clog2(OAM_DEPTH + 1);
  localparam int CW = $clog2(SLOTS + 1);

  localparam logic [9:0]    X_SCAN    = 10'(H_VISIBLE);
  localparam logic [9:0]    X_SWAP    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(OAM_DEPTH);
  localparam logic [PW-1:0] PH_AHOLD  = PW'(OAM_DEPTH - 1);
  localparam logic [CW-1:0] SLOTS_C   = CW'(SLOTS);
  localparam logic [10:0]   TW11      = 11'(TILE_W);
  localparam logic [10:0]   TH11      = 11'(TILE_H);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] phase;
  logic [9:0]    ty;
  logic [CW-1:0] count;
  logic          shadow_ovf;
  logic [31:0]   shadow [SLOTS];
  logic [31:0]   active [SLOTS];

  logic          scan_start;
  logic          swap;
  logic          eval;
  logic          vhit;
  logic          capture;
  logic          drop;
  logic [10:0]   rd_py11;
  logic [10:0]   ty11;

  assign scan_start = (state == IDLE) && (x == X_SCAN);
  assign swap       = (x == X_SWAP);

  // The read data in phase p (p >= 1) belongs to OAM address p-1. A swap
  // edge aborts the scan, and nothing is evaluated on that edge.
  assign eval    = (state == SCAN) && (phase != '0) && !swap;
  assign rd_py11 = {1'b0, oam_rd_data[17:8]};
  assign ty11    = {1'b0, ty};
  assign vhit    = oam_rd_data[28] && (ty11 >= rd_py11) && (ty11 < (rd_py11 + TH11));
  assign capture = eval && vhit && (count < SLOTS_C);
  assign drop    = eval && vhit && (count == SLOTS_C);

  assign scan_busy = (state == SCAN);

  // Scan sequencer: target line latch, address walk, hit count and overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      oam_addr   <= '0;
      ty         <= '0;
      count      <= '0;
      shadow_ovf <= 1'b0;
    end else if (swap) begin
      state    <= IDLE;
      phase    <= '0;
      oam_addr <= '0;
    end else if (scan_start) begin
      state      <= SCAN;
      phase      <= '0;
      oam_addr   <= '0;
      count      <= '0;
      shadow_ovf <= 1'b0;
      ty         <= (y == Y_LAST) ? 10'd0 : (y + 10'd1);
    end else if (state == SCAN) begin
      if (capture) begin
        count <= count + CW'(1);
      end
      if (drop) begin
        shadow_ovf <= 1'b1;
      end
      if (phase == PH_LAST) begin
        state    <= IDLE;
        oam_addr <= '0;
      end else begin
        phase <= phase + PW'(1);
        if (phase < PH_AHOLD) begin
          oam_addr <= oam_addr + 1'b1;
        end
      end
    end
  end

  // Shadow buffer: cleared when a scan starts, filled in OAM order by hits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        shadow[i] <= 32'h0;
      end
    end else if (scan_start && !swap) begin
      for (int i = 0; i < SLOTS; i++) begin
        shadow[i] <= 32'h0;
      end
    end else if (capture) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (count == CW'(i)) begin
          shadow[i] <= oam_rd_data;
        end
      end
    end
  end

  // Active buffer and line overflow flag take the shadow contents at line end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        active[i] <= 32'h0;
      end
      line_overflow <= 1'b0;
    end else if (swap) begin
      for (int i = 0; i < SLOTS; i++) begin
        active[i] <= shadow[i];
      end
      line_overflow <= shadow_ovf;
    end
  end

  // Per-slot horizontal coverage of the current pixel. Empty slots are all
  // zero, and their clear enable bit keeps them from claiming a pixel.
  logic [SLOTS-1:0] hhit;
  genvar gi;
  for (gi = 0; gi < SLOTS; gi++) begin : g_hhit
    logic [10:0] px11;
    logic [10:0] x11;
    assign px11      = {1'b0, active[gi][27:18]};
    assign x11       = {1'b0, x};
    assign hhit[gi]  = active[gi][28] && (x11 >= px11) && (x11 < (px11 + TW11));
  end

  // Priority pick: the lowest slot with coverage wins
  logic [31:0] sel;
  always_comb begin
    sel = 32'h0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (hhit[i]) begin
        sel = active[i];
      end
    end
  end

  // Registered pixel word, forced to zero outside the visible area
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oam_data <= 32'h0;
    end else begin
      oam_data <= video_on ? sel : 32'h0;
    end
  end

endmodule

// File: tb/tb_oam_line_scanner.sv
// Testbench for oam_line_scanner: drives whole scanlines and compares every
// pixel against a reference model. The model rebuilds each line's object list
// straight from the OAM array with queue operations.
module tb_oam_line_scanner;

  localparam int OAM_DEPTH = 8;
  localparam int SLOTS     = 4;
  localparam int TILE_W    = 32;
  localparam int TILE_H    = 32;
  localparam int H_VISIBLE = 640;
  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;
  localparam int V_VISIBLE = 480;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic [31:0] oam_rd_data;
  logic [2:0]  oam_addr;
  logic [31:0] oam_data;
  logic        line_overflow;
  logic        scan_busy;

  int checks = 0;
  int errors = 0;
  int cur_x  = 0;
  int cur_y  = 0;

  logic [31:0] mem [OAM_DEPTH];

  // Reference state: the list shown on this line, and the list found for the next
  logic [31:0] cur_q [$];
  logic [31:0] nxt_q [$];
  bit          cur_ovf = 1'b0;
  bit          nxt_ovf = 1'b0;
  bit          scan_on = 1'b0;

  oam_line_scanner #(
    .OAM_DEPTH (OAM_DEPTH),
    .SLOTS     (SLOTS),
    .TILE_W    (TILE_W),
    .TILE_H    (TILE_H),
    .H_VISIBLE (H_VISIBLE),
    .H_TOTAL   (H_TOTAL),
    .V_TOTAL   (V_TOTAL)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .x             (x),
    .y             (y),
    .video_on      (video_on),
    .oam_rd_data   (oam_rd_data),
    .oam_addr      (oam_addr),
    .oam_data      (oam_data),
    .line_overflow (line_overflow),
    .scan_busy     (scan_busy)
  );

  always #5 clk = ~clk;

  // OAM RAM with a registered read port
  always @(posedge clk) oam_rd_data <= mem[oam_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s y=%0d x=%0d: observed %h expected %h", tag, cur_y, cur_x, obs, expv);
    end
  endtask

  function automatic logic [31:0] obj(input bit en, input int px, input int py, input int typ, input int low);
    logic [31:0] w;
    w        = 32'h0;
    w[30:29] = typ[1:0];
    w[28]    = en;
    w[27:18] = px[9:0];
    w[17:8]  = py[9:0];
    w[7:0]   = low[7:0];
    return w;
  endfunction

  task automatic clear_oam();
    for (int k = 0; k < OAM_DEPTH; k++) mem[k] = 32'h0;
  endtask

  // Objects covering the line after yv, in OAM order, capped at SLOTS
  task automatic model_scan(input int yv);
    int ty;
    int py;
    ty = (yv == V_TOTAL - 1) ? 0 : yv + 1;
    nxt_q.delete();
    nxt_ovf = 1'b0;
    for (int k = 0; k < OAM_DEPTH; k++) begin
      py = int'(mem[k][17:8]);
      if (mem[k][28] && ty >= py && ty < py + TILE_H) begin
        if (nxt_q.size() < SLOTS) nxt_q.push_back(mem[k]);
        else nxt_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] exp_pix(input int xv, input bit von);
    int px;
    if (!von) return 32'h0;
    foreach (cur_q[i]) begin
      px = int'(cur_q[i][27:18]);
      if (xv >= px && xv < px + TILE_W) return cur_q[i];
    end
    return 32'h0;
  endfunction

  // One full scanline; rst_at >= 0 pulses reset for 2 cycles at that column
  task automatic run_line(input int yv, input int rst_at);
    bit          von;
    logic [31:0] expd;
    bit          expb;
    int          shown;
    shown = cur_q.size();
    cur_y = yv;
    for (int xv = 0; xv < H_TOTAL; xv++) begin
      @(negedge clk);
      cur_x    = xv;
      von      = (xv < H_VISIBLE) && (yv < V_VISIBLE);
      x        = 10'(xv);
      y        = 10'(yv);
      video_on = von;
      if (rst_at >= 0 && xv == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_addr", {29'b0, oam_addr}, 32'h0);
        check("rst_data", oam_data, 32'h0);
        check("rst_ovf", {31'b0, line_overflow}, 32'h0);
        check("rst_busy", {31'b0, scan_busy}, 32'h0);
        cur_q.delete();
        nxt_q.delete();
        cur_ovf = 1'b0;
        nxt_ovf = 1'b0;
        scan_on = 1'b0;
      end
      if (rst_at >= 0 && xv == rst_at + 2) rst = 1'b0;
      if (xv == H_VISIBLE && !rst) begin
        model_scan(yv);
        scan_on = 1'b1;
      end
      @(posedge clk);
      #1;
      expd = rst ? 32'h0 : exp_pix(xv, von);
      expb = scan_on && (xv >= H_VISIBLE) && (xv <= H_VISIBLE + OAM_DEPTH);
      if (xv == H_TOTAL - 1 && !rst) begin
        cur_q   = nxt_q;
        cur_ovf = nxt_ovf;
        scan_on = 1'b0;
      end
      check("oam_data", oam_data, expd);
      check("line_overflow", {31'b0, line_overflow}, {31'b0, cur_ovf});
      check("scan_busy", {31'b0, scan_busy}, {31'b0, expb});
    end
    $display("line %0d: objects shown %0d, next line %0d, overflow %0d, checks %0d, errors %0d",
             yv, shown, cur_q.size(), cur_ovf, checks, errors);
  endtask

  initial begin
    int ry;
    int py;
    rst      = 1'b1;
    x        = 10'd0;
    y        = 10'd0;
    video_on = 1'b0;
    clear_oam();
    repeat (3) @(posedge clk);
    #1;
    check("reset_addr", {29'b0, oam_addr}, 32'h0);
    check("reset_data", oam_data, 32'h0);
    check("reset_ovf", {31'b0, line_overflow}, 32'h0);
    check("reset_busy", {31'b0, scan_busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single object at (100,50)
    clear_oam();
    mem[2] = obj(1'b1, 100, 50, 1, 8'h2C);
    for (int l = 48; l <= 52; l++) run_line(l, -1);
    for (int l = 80; l <= 83; l++) run_line(l, -1);

    // Six objects on one band: only the first four survive, with overflow
    clear_oam();
    for (int k = 0; k < 6; k++) mem[k] = obj(1'b1, 40 * k, 10, k, 8'h10 + k);
    for (int l = 9; l <= 12; l++) run_line(l, -1);
    for (int l = 40; l <= 43; l++) run_line(l, -1);

    // Overlapping objects: lower OAM address wins
    clear_oam();
    mem[1] = obj(1'b1, 200, 200, 2, 8'hA1);
    mem[5] = obj(1'b1, 210, 200, 3, 8'hB5);
    for (int l = 199; l <= 202; l++) run_line(l, -1);

    // Frame wrap and bottom edge
    clear_oam();
    mem[0] = obj(1'b1, 300, 0, 1, 8'h01);
    mem[3] = obj(1'b1, 50, 470, 2, 8'h33);
    for (int l = 469; l <= 471; l++) run_line(l, -1);
    for (int l = 478; l <= 480; l++) run_line(l, -1);
    run_line(V_TOTAL - 1, -1);
    run_line(0, -1);
    run_line(1, -1);

    // Reset in the middle of a scan
    clear_oam();
    mem[2] = obj(1'b1, 100, 50, 1, 8'h2C);
    run_line(49, -1);
    run_line(50, H_VISIBLE + 3);
    run_line(51, -1);
    run_line(52, -1);

    // Disabled objects never show
    clear_oam();
    mem[0] = obj(1'b0, 0, 0, 3, 8'hFF);
    mem[1] = obj(1'b0, 20, 1, 1, 8'h77) | 32'h8000_0000;
    run_line(V_TOTAL - 1, -1);
    run_line(0, -1);
    run_line(1, -1);

    // Random OAM contents around a random line
    for (int r = 0; r < 6; r++) begin
      ry = int'($urandom_range(0, V_TOTAL - 1));
      for (int k = 0; k < OAM_DEPTH; k++) begin
        if ($urandom_range(0, 7) == 0) py = 1000;
        else py = ry - int'($urandom_range(0, 40));
        if (py < 0) py = 0;
        mem[k] = obj($urandom_range(0, 3) != 0, int'($urandom_range(0, 700)), py,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
        mem[k][31] = 1'($urandom_range(0, 1));
      end
      for (int l = -1; l <= 2; l++) run_line((ry + l + V_TOTAL) % V_TOTAL, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
